// File: rtl/vector_pkg.sv
// Shared types and constants for the test-vector assembler: 96-bit vector type,
// assembler FSM states, dword count and error bit positions.
package vector_pkg;

  localparam int DWORDS_PER_VECTOR = 3;
  localparam int DWORD_W           = 32;
  localparam int VEC_W             = DWORDS_PER_VECTOR * DWORD_W;

  localparam int ERR_UNSOLICITED = 0;
  localparam int ERR_BUSY_REQ    = 1;
  localparam int ERR_TIMEOUT     = 2;

  typedef logic [VEC_W-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_W0 = 2'd1,
    WAIT_W1 = 2'd2,
    WAIT_W2 = 2'd3
  } asm_state_t;

  // Dword 0 sits in the least significant lane of the vector.
  function automatic vec_t pack_vector(input logic [DWORD_W-1:0] w2,
                                       input logic [DWORD_W-1:0] w1,
                                       input logic [DWORD_W-1:0] w0);
    return {w2, w1, w0};
  endfunction

endpackage

// File: rtl/vector_fifo2.sv
// Two-entry FIFO of assembled vectors with occupancy count; entry0 is always the head
// and keeps its last value when the FIFO drains.
module vector_fifo2
  import vector_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  vec_t       push_data,
  input  logic       pop,
  output vec_t       head,
  output logic [1:0] count
);

  vec_t entry0;
  vec_t entry1;
  logic do_push;
  logic do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = entry0;

  // Shift-style storage: popping moves entry1 forward, so ordering is implicit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_data;
          else               entry1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) entry0 <= entry1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vector_assembler.sv
// Collects three read-return dwords per get_vector request into a vector and buffers
// up to two vectors. Optional dword-wait timeout enabled by VECTOR_ASM_TIMEOUT_EN.
module vector_assembler
  import vector_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        get_vector,
  input  logic [31:0] master_data_in,
  input  logic        master_data_in_val,
  output logic [95:0] vec_data,
  output logic        vec_valid,
  input  logic        vec_ready,
  output logic        asm_busy,
  output logic [1:0]  vec_count,
  output logic [2:0]  err,
  input  logic        err_clr
);

  asm_state_t  state;
  logic [31:0] word0;
  logic [31:0] word1;
  logic [2:0]  err_q;
  logic [2:0]  err_set;
  logic        timeout_hit;
  logic        push;
  logic        pop;
  vec_t        push_data;
  vec_t        head;

  assign asm_busy  = (state != IDLE) || (vec_count == 2'd2);
  assign vec_valid = (vec_count != 2'd0);
  assign vec_data  = head;
  assign err       = err_q;
  assign pop       = vec_valid && vec_ready;
  assign push      = (state == WAIT_W2) && master_data_in_val;
  assign push_data = pack_vector(master_data_in, word1, word0);

`ifdef VECTOR_ASM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES >= 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state != IDLE) && !master_data_in_val &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles between dwords; restarts whenever a dword lands or we leave the wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if ((state == IDLE) || master_data_in_val || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    err_set                  = '0;
    err_set[ERR_UNSOLICITED] = (state == IDLE) && master_data_in_val;
    err_set[ERR_BUSY_REQ]    = get_vector && asm_busy;
    err_set[ERR_TIMEOUT]     = timeout_hit;
  end

  // Collection FSM; err_clr wins over any error raised in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      word0 <= '0;
      word1 <= '0;
      err_q <= '0;
    end else begin
      err_q <= err_clr ? 3'b000 : (err_q | err_set);
      case (state)
        IDLE: begin
          if (get_vector && !asm_busy) state <= WAIT_W0;
        end
        WAIT_W0: begin
          if (master_data_in_val) begin
            word0 <= master_data_in;
            state <= WAIT_W1;
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        WAIT_W1: begin
          if (master_data_in_val) begin
            word1 <= master_data_in;
            state <= WAIT_W2;
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        WAIT_W2: begin
          if (master_data_in_val || timeout_hit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  vector_fifo2 u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (vec_count)
  );

endmodule
